// File: rtl/alarm_event_gen_pkg.sv
// Shared alarm definitions: phase encoding, time-field widths and range limits,
// plus the index map of the timeout pulses steered out of the seconds counter.
package alarm_event_gen_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ARMED,
    PH_RINGING,
    PH_SNOOZING
  } phase_e;

  localparam int EXP_SNOOZE   = 0;
  localparam int EXP_TIMEOUT  = 1;
  localparam int EXP_AUTO_OFF = 2;
  localparam int EXP_N        = 3;

  // Ringing dominates so the illegal ringing+snoozing combination decodes as RINGING.
  function automatic phase_e decode_phase(input logic set_flag,
                                          input logic ring_flag,
                                          input logic snooze_flag);
    if (ring_flag)        return PH_RINGING;
    else if (snooze_flag) return PH_SNOOZING;
    else if (set_flag)    return PH_ARMED;
    else                  return PH_IDLE;
  endfunction

endpackage

// File: rtl/alarm_event_gen_if.sv
// Bundle between the timekeeper/alarm FSM side (master) and the event generator (slave).
interface alarm_event_gen_if #(
  parameter int CNT_W    = 9,
  parameter int SNOOZE_W = 2
);
  import alarm_event_gen_pkg::*;

  logic                sec_tick_i;
  logic [HOUR_W-1:0]   cur_hour_i;
  logic [MIN_W-1:0]    cur_min_i;
  logic [SEC_W-1:0]    cur_sec_i;
  logic [HOUR_W-1:0]   alarm_hour_i;
  logic [MIN_W-1:0]    alarm_min_i;
  logic                in_alarm_set_i;
  logic                in_alarm_i;
  logic                in_snooze_i;
  logic                alarm_start_o;
  logic                alarm_timeout_o;
  logic                snooze_timeout_o;
  logic                auto_off_o;
  logic [CNT_W-1:0]    secs_left_o;
  logic [SNOOZE_W-1:0] snooze_cnt_o;

  modport master (
    output sec_tick_i, cur_hour_i, cur_min_i, cur_sec_i,
    output alarm_hour_i, alarm_min_i,
    output in_alarm_set_i, in_alarm_i, in_snooze_i,
    input  alarm_start_o, alarm_timeout_o, snooze_timeout_o, auto_off_o,
    input  secs_left_o, snooze_cnt_o
  );

  modport slave (
    input  sec_tick_i, cur_hour_i, cur_min_i, cur_sec_i,
    input  alarm_hour_i, alarm_min_i,
    input  in_alarm_set_i, in_alarm_i, in_snooze_i,
    output alarm_start_o, alarm_timeout_o, snooze_timeout_o, auto_off_o,
    output secs_left_o, snooze_cnt_o
  );

endinterface

// File: rtl/alarm_event_gen_sec_down_counter.sv
// Loadable seconds down-counter that holds at zero; the 1->0 step raises one registered
// expire pulse per asserted select bit, so the caller steers the pulse without extra delay.
module sec_down_counter #(
  parameter int CNT_W = 9,
  parameter int N_EXP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  input  logic [N_EXP-1:0] exp_sel_i,
  output logic [CNT_W-1:0] count_o,
  output logic [N_EXP-1:0] expire_o
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             hit_next;

  // Clear beats load, load beats a coincident tick.
  always_comb begin
    count_next = count_reg;
    hit_next   = 1'b0;
    if (clr_i) begin
      count_next = '0;
    end else if (load_i) begin
      count_next = load_val_i;
    end else if (tick_i && (count_reg != '0)) begin
      count_next = count_reg - CNT_W'(1);
      hit_next   = (count_reg == CNT_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_reg <= '0;
    else       count_reg <= count_next;
  end

  generate
    for (genvar gi = 0; gi < N_EXP; gi++) begin : g_expire
      logic expire_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) expire_reg <= 1'b0;
        else       expire_reg <= hit_next & exp_sel_i[gi];
      end
      assign expire_o[gi] = expire_reg;
    end
  endgenerate

  assign count_o = count_reg;

endmodule

// File: rtl/alarm_event_gen.sv
// Event pulses for the alarm FSM: start on time match while armed, and ring/snooze
// expiry steered to timeout, snooze-timeout or auto-off depending on the snooze budget.
module alarm_event_gen
  import alarm_event_gen_pkg::*;
#(
  parameter int ALARM_LEN_S  = 60,
  parameter int SNOOZE_LEN_S = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int CNT_W        = $clog2(((ALARM_LEN_S > SNOOZE_LEN_S) ? ALARM_LEN_S : SNOOZE_LEN_S) + 1),
  parameter int SNOOZE_W     = $clog2(MAX_SNOOZE + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alarm_event_gen_if.slave bus
);

  phase_e              phase;
  logic                match_next;
  logic                match_q;
  logic                match_prev_q;
  logic                ring_prev_q;
  logic                snooze_prev_q;
  logic                start_reg;
  logic                ring_entry;
  logic                snooze_entry;
  logic                cnt_clr;
  logic [CNT_W-1:0]    load_val;
  logic [EXP_N-1:0]    exp_sel;
  logic [EXP_N-1:0]    expire;
  logic [CNT_W-1:0]    count;
  logic [SNOOZE_W-1:0] snooze_cnt_reg;
  logic                budget_left;

  assign phase = decode_phase(bus.in_alarm_set_i, bus.in_alarm_i, bus.in_snooze_i);

  // Range guard keeps an out-of-range programmed alarm from ever matching.
  assign match_next = (bus.alarm_hour_i <= HOUR_W'(MAX_HOUR))
                    & (bus.alarm_min_i  <= MIN_W'(MAX_MIN))
                    & (bus.cur_hour_i == bus.alarm_hour_i)
                    & (bus.cur_min_i  == bus.alarm_min_i)
                    & (bus.cur_sec_i  == '0);

  assign ring_entry   = (phase == PH_RINGING)  && !ring_prev_q;
  assign snooze_entry = (phase == PH_SNOOZING) && !snooze_prev_q;
  assign cnt_clr      = (phase == PH_IDLE) || (phase == PH_ARMED);
  assign load_val     = ring_entry ? CNT_W'(ALARM_LEN_S) : CNT_W'(SNOOZE_LEN_S);
  assign budget_left  = (snooze_cnt_reg < SNOOZE_W'(MAX_SNOOZE));

  always_comb begin
    exp_sel               = '0;
    exp_sel[EXP_SNOOZE]   = (phase == PH_SNOOZING);
    exp_sel[EXP_TIMEOUT]  = (phase == PH_RINGING) &&  budget_left;
    exp_sel[EXP_AUTO_OFF] = (phase == PH_RINGING) && !budget_left;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_q        <= 1'b0;
      match_prev_q   <= 1'b0;
      ring_prev_q    <= 1'b0;
      snooze_prev_q  <= 1'b0;
      start_reg      <= 1'b0;
      snooze_cnt_reg <= '0;
    end else begin
      match_q       <= match_next;
      match_prev_q  <= match_q;
      ring_prev_q   <= (phase == PH_RINGING);
      snooze_prev_q <= (phase == PH_SNOOZING);
      // Edge-based so arming while the time already matches cannot start the alarm.
      start_reg     <= match_q & ~match_prev_q & (phase == PH_ARMED);
      if (cnt_clr)
        snooze_cnt_reg <= '0;
      else if (snooze_entry && budget_left)
        snooze_cnt_reg <= snooze_cnt_reg + SNOOZE_W'(1);
    end
  end

  sec_down_counter #(
    .CNT_W (CNT_W),
    .N_EXP (EXP_N)
  ) u_sec_down_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (ring_entry | snooze_entry),
    .load_val_i (load_val),
    .tick_i     (bus.sec_tick_i),
    .exp_sel_i  (exp_sel),
    .count_o    (count),
    .expire_o   (expire)
  );

  assign bus.alarm_start_o    = start_reg;
  assign bus.alarm_timeout_o  = expire[EXP_TIMEOUT];
  assign bus.snooze_timeout_o = expire[EXP_SNOOZE];
  assign bus.auto_off_o       = expire[EXP_AUTO_OFF];
  assign bus.secs_left_o      = count;
  assign bus.snooze_cnt_o     = snooze_cnt_reg;

endmodule

// File: doc/alarm_event_gen.md
# alarm_event_gen

Generates the event pulses that drive the alarm-clock state machine: alarm start on a time match, ring-duration timeout, snooze-duration timeout and auto-off after too many snoozes. Sits directly upstream of the alarm FSM. Consumes the timekeeper's time-of-day and 1 Hz tick plus the FSM's registered state flags. Produces single-cycle registered pulses that feed the FSM's `alarm_start_i`, `alarm_timeout_i`, `alarm_snooze_timeout_i` and `alarm_off_i` (ORed with the user button) inputs.

## Interface
- `ALARM_LEN_S`, 60: ring duration in seconds; must be ≥1.
- `SNOOZE_LEN_S`, 300: snooze duration in seconds; must be ≥1.
- `MAX_SNOOZE`, 3: number of snoozes allowed before auto-off; must be ≥1.
- `CNT_W`, `$clog2(max(ALARM_LEN_S,SNOOZE_LEN_S)+1)`: width of the seconds counter.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `sec_tick_i`  in  1  one-cycle pulse, once per second.
- `cur_hour_i`  in  5  current hour, 0–23.
- `cur_min_i`  in  6  current minute, 0–59.
- `cur_sec_i`  in  6  current second, 0–59.
- `alarm_hour_i`  in  5  programmed alarm hour.
- `alarm_min_i`  in  6  programmed alarm minute.
- `in_alarm_set_i`  in  1  FSM flag: not idle.
- `in_alarm_i`  in  1  FSM flag: ringing.
- `in_snooze_i`  in  1  FSM flag: snoozing.
- `alarm_start_o`  out  1  pulse: alarm time reached while armed.
- `alarm_timeout_o`  out  1  pulse: ring duration expired, snooze budget remaining.
- `snooze_timeout_o`  out  1  pulse: snooze duration expired.
- `auto_off_o`  out  1  pulse: ring expired with snooze budget exhausted.
- `secs_left_o`  out  CNT_W  seconds remaining in the current ring/snooze phase; 0 otherwise.
- `snooze_cnt_o`  out  `$clog2(MAX_SNOOZE+1)`  snoozes taken in this alarm session.

## Operation
- Phase is decoded from the flags:
  - RINGING = `in_alarm_i`
  - SNOOZING = `in_snooze_i`
  - ARMED = `in_alarm_set_i` & neither of the above
  - IDLE otherwise
  - `in_alarm_i` and `in_snooze_i` both high is illegal; treat it as RINGING.
- Match:
  - match = (`cur_hour_i`==`alarm_hour_i`) & (`cur_min_i`==`alarm_min_i`) & (`cur_sec_i`==0), registered into `match_q`.
  - `alarm_start_o` fires on the rising edge of `match_q` while ARMED.
  - Arming during an already-true match produces no start.
  - Out-of-range alarm values (hour>23, min>59) never match.
- Seconds counter (shared, because the phases are exclusive):
  - On entry into RINGING (rising edge of `in_alarm_i`, including SNOOZING→RINGING): load `ALARM_LEN_S`.
  - On entry into SNOOZING: load `SNOOZE_LEN_S`.
  - While in a phase, each `sec_tick_i` decrements the counter.
  - Decrement from 1 to 0 fires exactly one pulse:
    - SNOOZING → `snooze_timeout_o`.
    - RINGING with `snooze_cnt` < `MAX_SNOOZE` → `alarm_timeout_o`.
    - RINGING with `snooze_cnt` == `MAX_SNOOZE` → `auto_off_o`.
  - At 0 the counter holds; no repeat pulse.
  - In IDLE or ARMED the counter is forced to 0.
- Snooze count:
  - Increments on each entry into SNOOZING, whether by timeout or forced snooze.
  - Saturates at `MAX_SNOOZE`.
  - Clears whenever the phase is IDLE or ARMED.

## Timing
- Reset: all outputs 0; `match_q`, previous-flag registers, counter and snooze count all 0.
- All outputs are registered. Pulses last exactly one cycle.
- Start: `alarm_start_o` is high 2 cycles after the cycle in which the time inputs first match (match register, then edge register).
- Timeout: a pulse is high the cycle after the `sec_tick_i` that takes the counter 1→0. The FSM changes state one cycle later.
- Phase entry is detected one cycle after the flag rises. A `sec_tick_i` in the entry-load cycle is ignored (the load wins), so the phase lasts between LEN and LEN+1 ticks worth of time.
- Flag drops (e.g. user `alarm_off`) in the same cycle as a pending tick: the counter clears and no pulse fires.
- `rst_i` mid-phase clears everything immediately (asynchronous). No pulse fires on reset release.

## Structure
- The shared alarm package holds:
  - the phase enum (IDLE/ARMED/RINGING/SNOOZING);
  - time-field widths (`HOUR_W`=5, `MIN_W`=6, `SEC_W`=6);
  - max-value constants (23/59).
- One natural sub-module: `sec_down_counter` (load value, load strobe, tick, clear; outputs count and a one-cycle expire pulse).
- The top level handles match/edge detection, phase decode, pulse steering and the snooze counter.

## Test plan
- Arm at 07:30, sweep time 07:29:59→07:30:00 with ticks → `alarm_start_o` one pulse, 2 cycles after match. Same sweep while IDLE → no pulse.
- Ring (`ALARM_LEN_S`=4), 4 ticks → `alarm_timeout_o` once, cycle after 4th tick; `secs_left_o` 4,3,2,1,0.
- Snooze (`SNOOZE_LEN_S`=3): 3 ticks → `snooze_timeout_o` once. Drop `in_snooze_i` after 2 ticks → no pulse, `secs_left_o`=0.
- `MAX_SNOOZE`=2: ring→snooze→ring→snooze→ring expiry → `auto_off_o` (not `alarm_timeout_o`); `snooze_cnt_o`=2, clears on return to IDLE.
- `sec_tick_i` coincident with RINGING entry → counter reads `ALARM_LEN_S`, not `ALARM_LEN_S`-1.
- Assert `rst_i` with `secs_left_o`=2 in RINGING → all outputs 0 immediately; no pulses after release.
